// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU: control-word bit positions, sequencer states, phases.
// Pure declarations; no timing or backpressure of its own.
package cpu4_pkg;

    localparam int CW_INCPC     = 12;
    localparam int CW_LOADPC_N  = 11;
    localparam int CW_LOADA     = 10;
    localparam int CW_LOADFLAGS = 9;
    localparam int CW_ALU_HI    = 8;
    localparam int CW_ALU_LO    = 6;
    localparam int CW_CSRAM     = 5;
    localparam int CW_WERAM     = 4;
    localparam int CW_OEALU     = 3;
    localparam int CW_OEIN      = 2;
    localparam int CW_CSOUT     = 1;
    localparam int CW_WEOUT     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    localparam logic PH_FETCH = 1'b0;
    localparam logic PH_EXEC  = 1'b1;

endpackage

// File: rtl/pc_register.sv
// Program counter: load has priority over increment; increment wraps at the top address.
// Latency: new value visible one cycle after the enabling edge.
// Backpressure: none; the caller qualifies load/inc with its own stall logic.
module pc_register #(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/microcode_sequencer.sv
// Fetch/execute sequencer: owns PC, IR and C/Z flags, addresses the microcode ROM, gates its word out.
// Latency: rom_addr registered; ctrl_out combinational from ctrl_word; two cycles minimum per instruction.
// Backpressure: prog_valid low stalls FETCH, and EXEC when the word needs prog_byte; ctrl_out is 0 while stalled.
module microcode_sequencer
    import cpu4_pkg::*;
#(
    parameter int PC_W = 12,
    parameter int CW_W = 13,
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [7:0]      prog_byte,
    input  logic            prog_valid,
    input  logic [CW_W-1:0] ctrl_word,
    input  logic            alu_c,
    input  logic            alu_z,
    output logic [PC_W-1:0] prog_addr,
    output logic [6:0]      rom_addr,
    output logic [CW_W-1:0] ctrl_out,
    output logic [3:0]      operand,
    output logic            busy
);

    state_t      state_q, state_d;
    logic [7:0]  ir_q, ir_d;
    logic        c_q, c_d;
    logic        z_q, z_d;
    logic [6:0]  rom_addr_q, rom_addr_d;
    logic        pc_load;
    logic        pc_inc;
    logic        need_byte;

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        c_d       = c_q;
        z_d       = z_q;
        ctrl_out  = '0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        need_byte = !ctrl_word[CW_LOADPC_N] || ctrl_word[CW_INCPC];

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Flags deliberately ignored here even if the fetch word sets loadFlags.
                if (prog_valid) begin
                    ctrl_out = ctrl_word;
                    ir_d     = prog_byte;
                    pc_inc   = ctrl_word[CW_INCPC];
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!need_byte || prog_valid) begin
                    ctrl_out = ctrl_word;
                    pc_load  = !ctrl_word[CW_LOADPC_N];
                    pc_inc   = ctrl_word[CW_INCPC];
                    if (ctrl_word[CW_LOADFLAGS]) begin
                        c_d = alu_c;
                        z_d = alu_z;
                    end
                    state_d = run ? ST_FETCH : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Address the ROM for the state being entered, so EXEC sees the freshly loaded IR and flags.
        rom_addr_d = {ir_d[7 -: OP_W], c_d, z_d, (state_d == ST_EXEC) ? PH_EXEC : PH_FETCH};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            c_q        <= 1'b0;
            z_q        <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            c_q        <= c_d;
            z_q        <= z_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    pc_register #(
        .PC_W (PC_W)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .inc      (pc_inc),
        .load_val (PC_W'({ir_q[3:0], prog_byte})),
        .pc       (prog_addr)
    );

    assign rom_addr = rom_addr_q;
    assign operand  = ir_q[3:0];
    assign busy     = (state_q != ST_IDLE);

endmodule
